clock_ratio_detector: RTL and testbench

- Receive-side companion to the team's clock dividers: measures a divided/slow periodic signal against the system clock.
- Synchronizes `sig_in`, then measures its period and high time in `clk` cycles, rising edge to rising edge.
- Reports each measurement with a one-cycle valid pulse.
- Asserts `locked` once the measured ratio is stable; flags inputs too slow to measure.

---
 rtl/clock_ratio_detector.sv | 108 ++++++++++
 tb/tb_clock_ratio_detector.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_ratio_detector.sv
// Measures period and high time of a slow periodic input in clk cycles
// and reports lock once consecutive measurements agree.
module clock_ratio_detector #(
  parameter int CNT_W       = 8,
  parameter int LOCK_COUNT  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_COUNT);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   s_prev;
  logic                   rise;
  logic                   has_prev;
  logic                   same;
  logic [CNT_W-1:0]       period_cnt;
  logic [CNT_W-1:0]       high_cnt;
  logic [3:0]             match_cnt;
  logic [3:0]             match_next;

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~s_prev;
  assign same = (period_cnt == period) &&
                (high_cnt == high_time);

  // period/high_time still hold the previous measurement here
  always_comb begin
    match_next = 4'd0;
    if (has_prev && same) begin
      if (match_cnt == LOCK_N)
        match_next = match_cnt;
      else
        match_next = match_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sync       <= '0;
      s_prev     <= 1'b0;
      period_cnt <= '0;
      high_cnt   <= '0;
      match_cnt  <= 4'd0;
      has_prev   <= 1'b0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], sig_in};
      s_prev     <= s;
      meas_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) begin
            period_cnt <= CNT_ONE;
            high_cnt   <= CNT_ONE;
            has_prev   <= 1'b0;
            state      <= MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period     <= period_cnt;
            high_time  <= high_cnt;
            meas_valid <= 1'b1;
            overflow   <= 1'b0;
            period_cnt <= CNT_ONE;
            high_cnt   <= CNT_ONE;
            has_prev   <= 1'b1;
            match_cnt  <= match_next;
            locked     <= (match_next == LOCK_N);
          end else if (period_cnt == CNT_MAX) begin
            overflow  <= 1'b1;
            locked    <= 1'b0;
            match_cnt <= 4'd0;
            state     <= IDLE;
          end else begin
            period_cnt <= period_cnt + CNT_ONE;
            high_cnt   <= high_cnt + CNT_W'(s);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_ratio_detector.sv
// Randomised and directed bench for clock_ratio_detector with a
// timestamp/queue model of the measured waveform.
module tb_clock_ratio_detector;

  localparam int W   = 8;
  localparam int L   = 4;
  localparam int SS  = 3;
  localparam int MAX = 255;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sig_in = 1'b0;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         meas_valid;
  logic         locked;
  logic         overflow;

  int tests = 0;
  int fails = 0;
  int vcount = 0;
  bit chk = 0;

  always #5 clk = ~clk;

  clock_ratio_detector #(
    .CNT_W(W),
    .LOCK_COUNT(L),
    .SYNC_STAGES(SS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sig_in(sig_in),
    .period(period),
    .high_time(high_time),
    .meas_valid(meas_valid),
    .locked(locked),
    .overflow(overflow)
  );

  // model: delayed copy of sig_in, window of levels since last rise,
  // and the recent measurements since arming
  bit           q_hist[$];
  bit           win[$];
  int           mp[$];
  int           mh[$];
  bit           m_s, m_sp, armed, m_rise;
  int           m_ones;
  logic [W-1:0] e_period, e_high;
  bit           e_valid, e_locked, e_ovf;

  function automatic bit stable();
    if (mp.size() < L + 1) return 0;
    foreach (mp[i])
      if (mp[i] != mp[0] || mh[i] != mh[0]) return 0;
    return 1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      q_hist.delete(); win.delete();
      mp.delete(); mh.delete();
      m_s = 0; m_sp = 0; armed = 0;
      e_period = '0; e_high = '0;
      e_valid = 0; e_locked = 0; e_ovf = 0;
    end else begin
      m_rise = m_s && !m_sp;
      e_valid = 0;
      if (armed && m_rise) begin
        m_ones = 0;
        foreach (win[i]) m_ones += int'(win[i]);
        e_period = W'(win.size());
        e_high   = W'(m_ones);
        e_valid  = 1;
        e_ovf    = 0;
        mp.push_back(win.size());
        mh.push_back(m_ones);
        if (mp.size() > L + 1) begin
          void'(mp.pop_front());
          void'(mh.pop_front());
        end
        e_locked = stable();
        win.delete();
      end else if (armed && win.size() == MAX) begin
        e_ovf = 1;
        e_locked = 0;
        armed = 0;
        mp.delete(); mh.delete();
      end else if (!armed && m_rise) begin
        armed = 1;
        win.delete();
      end
      if (armed) win.push_back(m_s);
      q_hist.push_back(sig_in);
      if (q_hist.size() > SS) void'(q_hist.pop_front());
      m_sp = m_s;
      m_s = (q_hist.size() == SS) ? q_hist[0] : 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk) begin
      tests++;
      if (meas_valid) vcount++;
      if ({period, high_time, meas_valid, locked, overflow} !==
          {e_period, e_high, e_valid, e_locked, e_ovf}) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t got p=%0d h=%0d v=%0b l=%0b o=%0b want p=%0d h=%0d v=%0b l=%0b o=%0b",
                 $time, period, high_time, meas_valid, locked, overflow,
                 e_period, e_high, e_valid, e_locked, e_ovf);
      end
    end
  end

  task automatic lit(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input int n);
    sig_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic pat(input int h, input int l, input int reps);
    repeat (reps) begin
      drive(1'b1, h);
      drive(1'b0, l);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  int v0, lat, h, l, r;

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk = 1;
    lit("rst_period", int'(period), 0);
    lit("rst_high", int'(high_time), 0);
    lit("rst_flags", int'({meas_valid, locked, overflow}), 0);
    reset = 1'b0;

    // period 5, high 2
    drive(1'b0, 4);
    v0 = vcount;
    pat(2, 3, 8);
    lit("t1_valids", vcount - v0, 7);
    lit("t1_period", int'(period), 5);
    lit("t1_high", int'(high_time), 2);
    lit("t1_locked", int'(locked), 1);
    lit("t1_ovf", int'(overflow), 0);
    lit("t1_model_p", int'(e_period), 5);
    lit("t1_model_l", int'(e_locked), 1);

    // switch to 3/3: drop and re-lock
    pat(3, 3, 7);
    lit("t3_period", int'(period), 6);
    lit("t3_high", int'(high_time), 3);
    lit("t3_locked", int'(locked), 1);

    // stuck high -> overflow, then recover
    drive(1'b1, 300);
    lit("t4_ovf", int'(overflow), 1);
    lit("t4_locked", int'(locked), 0);
    lit("t4_keep_p", int'(period), 6);
    lit("t4_model_o", int'(e_ovf), 1);
    drive(1'b0, 3);
    pat(2, 3, 4);
    lit("t4_ovf_clr", int'(overflow), 0);
    lit("t4_period", int'(period), 5);

    // reset while locked, sig_in high at release
    pat(2, 3, 6);
    lit("t5_pre_lock", int'(locked), 1);
    sig_in = 1'b1;
    do_reset();
    lit("t5_zero", int'({period, high_time, meas_valid, locked, overflow}), 0);
    drive(1'b1, 2);
    drive(1'b0, 3);
    pat(2, 3, 3);
    lit("t5_period", int'(period), 5);
    lit("t5_locked", int'(locked), 0);

    // fastest input
    pat(1, 1, 10);
    lit("t2_period", int'(period), 2);
    lit("t2_high", int'(high_time), 1);
    lit("t2_locked", int'(locked), 1);

    // latency: valid SS+1 edges after the sampling edge of second rise
    do_reset();
    drive(1'b0, 10);
    drive(1'b1, 3);
    drive(1'b0, 3);
    sig_in = 1'b1;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (meas_valid && lat == 0) lat = k;
    end
    lit("t6_latency", lat, SS + 1);
    @(negedge clk);
    drive(1'b0, 4);

    // random segments
    repeat (30) begin
      h = $urandom_range(1, 6);
      l = $urandom_range(1, 6);
      r = $urandom_range(2, 8);
      pat(h, l, r);
      if ($urandom_range(0, 7) == 0)
        drive(1'($urandom_range(0, 1)), $urandom_range(1, 3));
      if ($urandom_range(0, 11) == 0) begin
        sig_in = 1'($urandom_range(0, 1));
        do_reset();
      end
    end
    drive(1'b0, 270);
    lit("rand_ovf", int'(overflow), 1);
    pat(4, 2, 4);

    chk = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
